byte_strobe_tx: RTL and testbench
=================================

Name: byte_strobe_tx

Overview:
- Transmit side of the team's 8-bit enable-strobed byte interface.
- The receiving capture register loads a byte once per rising edge of its enable. It re-arms only after enable returns low.
- This block buffers bytes from a local producer in a small FIFO. It replays them as one clean enable pulse per byte: data stable before the rising edge, a guaranteed low gap after each pulse.
- Sits between motion-tracker control logic (writer) and downstream capture latches (reader).

Parameters:
ADDR_W, 3, FIFO address width; depth = 2**ADDR_W entries
SETUP_CYC, 1, cycles oData is held stable with oEn low before oEn rises (1..255)
HIGH_CYC, 2, cycles oEn is held high per byte (1..255)
LOW_CYC, 2, cycles oEn is held low after each pulse before the next byte may be presented (1..255)

Ports:
iClock  input  1  system clock, all logic on rising edge
iReset  input  1  asynchronous, active-low reset
iWrData  input  8  byte to enqueue
iWrEn  input  1  enqueue strobe, one byte per cycle while high
oFull  output  1  FIFO holds 2**ADDR_W entries
oEmpty  output  1  FIFO holds 0 entries
oCount  output  ADDR_W+1  current FIFO occupancy
oOverflow  output  1  sticky: a write was attempted while full
oData  output  8  byte presented to receiver (registered)
oEn  output  1  enable strobe to receiver (registered)
oBusy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, iReset=0):
  - FIFO pointers and count cleared; oCount=0, oEmpty=1, oFull=0.
  - oOverflow=0, oData=8'h00, oEn=0, oBusy=0, state=IDLE, phase counter=0.
  - Reset mid-pulse drops oEn immediately. A byte in flight is lost; queued bytes are discarded.
- FIFO:
  - Circular buffer; pointers wrap modulo 2**ADDR_W.
  - Full and empty are derived from the registered count at the start of the cycle.
  - A write with iWrEn=1 and oFull=0 stores iWrData and increments the count.
  - A write with iWrEn=1 and oFull=1 is dropped and sets oOverflow, even if a pop occurs in the same cycle. oOverflow clears only on reset.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - Data written into an empty FIFO is not visible to a pop in the same cycle (no bypass).
- FSM, 4 states; 8-bit phase counter reloaded on each transition:
  - IDLE: oEn=0. If oEmpty=0, pop head into oData on this edge and go to SETUP. Otherwise stay.
  - SETUP: oEn=0, oData held. After SETUP_CYC cycles go to STROBE; oEn goes to 1 on that edge.
  - STROBE: oEn=1, oData held. After HIGH_CYC cycles go to GAP; oEn goes to 0 on that edge.
  - GAP: oEn=0, oData held (last byte stays visible). After LOW_CYC cycles return to IDLE.
- oData changes only on the IDLE->SETUP edge, never while oEn=1 or in the cycle before oEn rises.
- Timing, byte written at edge k into an empty idle block:
  - oData valid after edge k+1.
  - oEn high after edge k+1+SETUP_CYC, low after edge k+1+SETUP_CYC+HIGH_CYC.
  - Back in IDLE after edge k+1+SETUP_CYC+HIGH_CYC+LOW_CYC.
- Steady-state byte period = 1+SETUP_CYC+HIGH_CYC+LOW_CYC cycles (6 with defaults).
- Exactly one oEn rising edge per popped byte. oEn never rises twice without at least LOW_CYC low cycles between pulses.
- Writes continue normally during any FSM state.

Test Plan:
- Reset, then write 8'hA5 at edge 10 -> oData=A5 after edge 11, oEn=1 after edges 12-13, oEn=0 from edge 14, oBusy=0 after edge 16, oEmpty=1 after edge 11.
- Burst-write 8'h01..8'h08 on consecutive cycles -> oFull=1 after 8th write less any pops (count never exceeds 8). Eight oEn pulses in order 01..08, period 6 cycles, oEn low ≥2 cycles between pulses.
- Fill FIFO to 8 while the FSM is held in a long pulse (HIGH_CYC=20), write 8'hFF -> write dropped, oOverflow=1 and stays 1. 8'hFF never appears on oData.
- Write while full in the same cycle as the IDLE pop -> write dropped, oOverflow=1, oCount goes 8->7.
- Assert iReset low during STROBE with 3 bytes queued -> oEn=0 immediately, oData=00, oCount=0, no further pulses after release.
- Model the receiving capture register on the bench (capture on oEn rising edge, re-arm on oEn low) and send 16 random bytes -> captured sequence equals written sequence exactly, no duplicates.

Source files
------------

// File: rtl/byte_strobe_tx.sv
// Transmit side of the enable-strobed byte interface: a small FIFO drained by
// an FSM that presents each byte with setup time, one clean enable pulse, then a low gap.
module byte_strobe_tx #(
  parameter int ADDR_W    = 3,
  parameter int SETUP_CYC = 1,
  parameter int HIGH_CYC  = 2,
  parameter int LOW_CYC   = 2
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [7:0]        iWrData,
  input  logic              iWrEn,
  output logic              oFull,
  output logic              oEmpty,
  output logic [ADDR_W:0]   oCount,
  output logic              oOverflow,
  output logic [7:0]        oData,
  output logic              oEn,
  output logic              oBusy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HIGH_LD  = 8'(HIGH_CYC - 1);
  localparam logic [7:0] LOW_LD   = 8'(LOW_CYC - 1);

  // state  | meaning
  // IDLE   | waiting for a queued byte; pops head into oData when one exists
  // SETUP  | oData stable, oEn low, before the rising edge
  // STROBE | oEn high
  // GAP    | oEn low, receiver re-arms before the next byte
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        phase_q, phase_d;
  logic [7:0]        data_q, data_d;
  logic              en_q, en_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;
  logic              wr_acc;
  logic              pop;

  assign oFull     = (count_q == FULL_CNT);
  assign oEmpty    = (count_q == '0);
  assign oCount    = count_q;
  assign oOverflow = ovf_q;
  assign oData     = data_q;
  assign oEn       = en_q;
  assign oBusy     = (state_q != IDLE);
  assign wr_acc    = iWrEn & ~oFull;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    data_d  = data_q;
    en_d    = en_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (!oEmpty) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = SETUP;
          phase_d = SETUP_LD;
        end
      end
      SETUP: begin
        if (phase_q == 8'd0) begin
          state_d = STROBE;
          phase_d = HIGH_LD;
          en_d    = 1'b1;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      STROBE: begin
        if (phase_q == 8'd0) begin
          state_d = GAP;
          phase_d = LOW_LD;
          en_d    = 1'b0;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      GAP: begin
        if (phase_q == 8'd0) begin
          state_d = IDLE;
          phase_d = 8'd0;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 8'd0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= IDLE;
      phase_q <= 8'd0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  // Storage has no reset; occupancy is governed entirely by the pointers/count.
  always_ff @(posedge iClock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= iWrData;
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (iWrEn && oFull) ovf_q <= 1'b1;
      case ({wr_acc, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_strobe_tx.sv
// Scoreboard bench: a cycle-level occupancy model predicts oCount/oOverflow and
// queues accepted bytes; a receiver-style monitor checks every enable pulse.
module tb_byte_strobe_tx;
  localparam int S = 1, H = 2, L = 2, DEPTH = 8;
  localparam int PERIOD = 1 + S + H + L;

  logic       iClock = 1'b0;
  logic       iReset = 1'b0;
  logic [7:0] iWrData = 8'h00;
  logic       iWrEn = 1'b0;
  logic       oFull, oEmpty, oOverflow, oEn, oBusy;
  logic [3:0] oCount;
  logic [7:0] oData;

  logic [7:0] iWrData2 = 8'h00;
  logic       iWrEn2 = 1'b0;
  logic       oFull2, oEmpty2, oOverflow2, oEn2, oBusy2;
  logic [3:0] oCount2;
  logic [7:0] oData2;

  byte_strobe_tx #(.ADDR_W(3), .SETUP_CYC(S), .HIGH_CYC(H), .LOW_CYC(L)) dut (
    .iClock(iClock), .iReset(iReset), .iWrData(iWrData), .iWrEn(iWrEn),
    .oFull(oFull), .oEmpty(oEmpty), .oCount(oCount), .oOverflow(oOverflow),
    .oData(oData), .oEn(oEn), .oBusy(oBusy));

  byte_strobe_tx #(.ADDR_W(3), .SETUP_CYC(1), .HIGH_CYC(20), .LOW_CYC(2)) dut_long (
    .iClock(iClock), .iReset(iReset), .iWrData(iWrData2), .iWrEn(iWrEn2),
    .oFull(oFull2), .oEmpty(oEmpty2), .oCount(oCount2), .oOverflow(oOverflow2),
    .oData(oData2), .oEn(oEn2), .oBusy(oBusy2));

  always #5 iClock = ~iClock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge iClock) cyc <= cyc + 1;

  // Reference model: a byte is popped whenever the FIFO holds something and a
  // full byte period has elapsed since the previous pop.
  int         m_cyc = 0, m_count = 0, m_next_ok = 0;
  bit         m_ovf = 1'b0, m_pop, m_acc;
  logic [7:0] exp_q[$];

  always @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      m_cyc = 0; m_count = 0; m_next_ok = 0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      m_pop = (m_count > 0) && (m_cyc >= m_next_ok);
      if (m_pop) m_next_ok = m_cyc + PERIOD;
      m_acc = 1'b0;
      if (iWrEn) begin
        if (m_count < DEPTH) begin
          m_acc = 1'b1;
          exp_q.push_back(iWrData);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_count = m_count + int'(m_acc) - int'(m_pop);
      m_cyc++;
    end
  end

  // Receiver model / monitor: captures on each oEn rising edge.
  logic       prev_en = 1'b0;
  logic [7:0] prev_data = 8'h00, held = 8'h00;
  int         low_run = 0, high_run = 0, n_pulses = 0;
  bit         seen_pulse = 1'b0;
  int         rise_q[$];

  always @(negedge iClock) begin
    if (!iReset) begin
      prev_en = 1'b0; seen_pulse = 1'b0; low_run = 0; high_run = 0;
    end else begin
      check("count", oCount, m_count);
      check("overflow", oOverflow, m_ovf);
      check("full", oFull, m_count == DEPTH);
      check("empty", oEmpty, m_count == 0);
      if (oEn && !prev_en) begin
        n_pulses++;
        rise_q.push_back(cyc);
        if (seen_pulse) check("low_gap_ok", low_run >= L, 1);
        check("setup_stable", oData, prev_data);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_pulse: got %0h expected no pulse", oData);
        end else begin
          check("byte", oData, exp_q.pop_front());
        end
        held = oData; high_run = 1; seen_pulse = 1'b1;
      end else if (oEn) begin
        check("hold_high", oData, held);
        high_run++;
      end else if (prev_en) begin
        check("pulse_width", high_run, H);
        low_run = 1;
      end else begin
        low_run++;
      end
      prev_en = oEn;
      prev_data = oData;
    end
  end

  logic       prev_en2 = 1'b0;
  logic [7:0] cap2[$];
  always @(negedge iClock) begin
    if (!iReset) prev_en2 = 1'b0;
    else begin
      if (oEn2 && !prev_en2) cap2.push_back(oData2);
      prev_en2 = oEn2;
    end
  end

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || oBusy || !oEmpty) && t < 1000) begin
      @(posedge iClock); #1; t++;
    end
    check({name, "_drained"}, t < 1000, 1);
  endtask

  initial begin
    int t;
    int pulses_before;
    #1;
    check("rst_count", oCount, 0);
    check("rst_empty", oEmpty, 1);
    check("rst_full", oFull, 0);
    check("rst_data", oData, 8'h00);
    check("rst_en", oEn, 0);
    check("rst_busy", oBusy, 0);
    check("rst_ovf", oOverflow, 0);
    repeat (3) @(posedge iClock);
    #1 iReset = 1'b1;
    repeat (2) @(posedge iClock);

    // Single byte timing, write captured at edge k
    #1 iWrData = 8'hA5; iWrEn = 1'b1;
    @(posedge iClock); #1 iWrEn = 1'b0;
    check("a5_k_count", oCount, 1);
    @(posedge iClock); #1;
    check("a5_k1_data", oData, 8'hA5);
    check("a5_k1_en", oEn, 0);
    check("a5_k1_empty", oEmpty, 1);
    check("a5_k1_busy", oBusy, 1);
    @(posedge iClock); #1 check("a5_k2_en", oEn, 1);
    @(posedge iClock); #1 check("a5_k3_en", oEn, 1);
    @(posedge iClock); #1 check("a5_k4_en", oEn, 0); check("a5_k4_busy", oBusy, 1);
    @(posedge iClock); #1 check("a5_k5_busy", oBusy, 1);
    @(posedge iClock); #1 check("a5_k6_busy", oBusy, 0);
    drain("a5");

    // Burst 01..08, back-to-back period
    rise_q.delete();
    for (int i = 1; i <= 8; i++) begin
      iWrData = 8'(i); iWrEn = 1'b1;
      @(posedge iClock); #1;
    end
    iWrEn = 1'b0;
    drain("burst");
    check("burst_pulses", rise_q.size(), 8);
    if (rise_q.size() == 8)
      for (int i = 1; i < 8; i++) check("burst_period", rise_q[i] - rise_q[i-1], PERIOD);

    // 16 random bytes with random spacing
    for (int i = 0; i < 16; i++) begin
      iWrData = 8'($urandom); iWrEn = 1'b1;
      @(posedge iClock); #1 iWrEn = 1'b0;
      repeat ($urandom_range(2, 9)) @(posedge iClock);
      #1;
    end
    drain("random");

    // Reset asserted mid-strobe with 3 bytes still queued
    for (int i = 0; i < 4; i++) begin
      iWrData = 8'hC1 + 8'(i); iWrEn = 1'b1;
      @(posedge iClock); #1;
    end
    iWrEn = 1'b0;
    check("rst_mid_en_pre", oEn, 1);
    check("rst_mid_count_pre", oCount, 3);
    #2 iReset = 1'b0;
    #1;
    check("rst_mid_en", oEn, 0);
    check("rst_mid_data", oData, 8'h00);
    check("rst_mid_count", oCount, 0);
    check("rst_mid_busy", oBusy, 0);
    pulses_before = n_pulses;
    repeat (2) @(posedge iClock);
    #1 iReset = 1'b1;
    repeat (30) @(posedge iClock);
    #1;
    check("rst_mid_no_pulse", n_pulses, pulses_before);
    check("rst_mid_busy_after", oBusy, 0);

    // Long pulse instance: fill during strobe, overflow, full write at pop edge
    cap2.delete();
    iWrData2 = 8'h30; iWrEn2 = 1'b1;
    @(posedge iClock); #1 iWrEn2 = 1'b0;
    t = 0;
    while (!oEn2 && t < 50) begin @(posedge iClock); #1; t++; end
    check("long_strobe_reached", t < 50, 1);
    for (int i = 0; i < 8; i++) begin
      iWrData2 = 8'h31 + 8'(i); iWrEn2 = 1'b1;
      @(posedge iClock); #1;
    end
    iWrEn2 = 1'b0;
    check("long_count8", oCount2, 8);
    check("long_full", oFull2, 1);
    check("long_ovf_pre", oOverflow2, 0);
    iWrData2 = 8'hFF; iWrEn2 = 1'b1;
    @(posedge iClock); #1 iWrEn2 = 1'b0;
    check("long_ovf_set", oOverflow2, 1);
    check("long_count_after_ff", oCount2, 8);
    t = 0;
    while (oBusy2 && t < 200) begin @(posedge iClock); #1; t++; end
    check("long_idle_reached", t < 200, 1);
    iWrData2 = 8'hEE; iWrEn2 = 1'b1;
    @(posedge iClock); #1 iWrEn2 = 1'b0;
    check("popfull_count7", oCount2, 7);
    check("popfull_ovf", oOverflow2, 1);
    check("popfull_busy", oBusy2, 1);
    t = 0;
    while ((oBusy2 || !oEmpty2) && t < 1000) begin @(posedge iClock); #1; t++; end
    check("long_drained", t < 1000, 1);
    check("long_ovf_sticky", oOverflow2, 1);
    check("long_pulses", cap2.size(), 9);
    if (cap2.size() == 9)
      for (int i = 0; i < 9; i++) check("long_byte", cap2[i], 8'h30 + 8'(i));

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
